// File: rtl/ram_pkg.sv
// Shared types and defaults for the 16x8 program/data memory and its loader.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    localparam int DEFAULT_ADDRESS_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH    = 8;

endpackage

// File: rtl/random_access_memory_if.sv
// Bus-side and loader-side signals of the memory; the memory is the slave.
interface random_access_memory_if
    import ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
);
    logic [ADDRESS_WIDTH-1:0] i_address;
    logic                     i_output_enable;
    logic                     i_write_enable;
    logic [DATA_WIDTH-1:0]    i_data;
    logic [DATA_WIDTH-1:0]    o_data;
    logic                     o_drive;
    logic                     i_program_mode;
    logic [DATA_WIDTH-1:0]    i_load_data;
    logic                     i_load_valid;
    logic                     o_load_ready;
    logic [ADDRESS_WIDTH-1:0] o_load_address;
    logic                     o_load_done;

    modport slave (
        input  i_address, i_output_enable, i_write_enable, i_data,
        input  i_program_mode, i_load_data, i_load_valid,
        output o_data, o_drive, o_load_ready, o_load_address, o_load_done
    );

    modport master (
        output i_address, i_output_enable, i_write_enable, i_data,
        output i_program_mode, i_load_data, i_load_valid,
        input  o_data, o_drive, o_load_ready, o_load_address, o_load_done
    );
endinterface

// File: rtl/random_access_memory_program_loader.sv
// RUN/LOAD/DONE sequencer that streams bytes into consecutive words.
// Status flags are registered; only the write strobe depends on i_load_valid.
module program_loader
    import ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_program_mode,
    input  logic                     i_load_valid,
    output logic                     o_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_wr_addr,
    output logic                     o_load_ready,
    output logic                     o_load_done,
    output logic                     o_run_active
);

    loader_state_e            state_q;
    logic [ADDRESS_WIDTH-1:0] ptr_q;
    logic                     ready_q;
    logic                     done_q;
    logic                     run_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_program_mode) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= '0;
                        ready_q <= 1'b1;
                        run_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Dropping the mode takes priority over a pending byte.
                    if (!i_program_mode) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        run_q   <= 1'b1;
                    end else if (i_load_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == {ADDRESS_WIDTH{1'b1}}) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!i_program_mode) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b0;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    run_q   <= 1'b1;
                end
            endcase
        end
    end

    assign o_wr_en      = ready_q & i_load_valid & i_program_mode & ~i_reset;
    assign o_wr_addr    = ptr_q;
    assign o_load_ready = ready_q;
    assign o_load_done  = done_q;
    assign o_run_active = run_q;

endmodule

// File: rtl/random_access_memory.sv
// 2**ADDRESS_WIDTH x DATA_WIDTH memory: combinational bus read, edge write,
// with a sequential program loader that masks the bus while loading.
module random_access_memory
    import ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    random_access_memory_if.slave bus
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    // Powers up zero; deliberately untouched by reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                     ld_wr_en;
    logic [ADDRESS_WIDTH-1:0] ld_wr_addr;
    logic                     ld_ready;
    logic                     ld_done;
    logic                     run_active;
    logic                     run_wr_en;

    program_loader #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_loader (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_program_mode (bus.i_program_mode),
        .i_load_valid   (bus.i_load_valid),
        .o_wr_en        (ld_wr_en),
        .o_wr_addr      (ld_wr_addr),
        .o_load_ready   (ld_ready),
        .o_load_done    (ld_done),
        .o_run_active   (run_active)
    );

    assign run_wr_en = run_active & bus.i_write_enable & ~i_reset;

    always_ff @(posedge i_clock) begin
        if (ld_wr_en) begin
            mem_q[ld_wr_addr] <= bus.i_load_data;
        end else if (run_wr_en) begin
            mem_q[bus.i_address] <= bus.i_data;
        end
    end

    assign bus.o_drive        = run_active & bus.i_output_enable;
    assign bus.o_data         = bus.o_drive ? mem_q[bus.i_address] : '0;
    assign bus.o_load_ready   = ld_ready;
    assign bus.o_load_done    = ld_done;
    assign bus.o_load_address = ld_wr_addr;

endmodule

// File: tb/tb_random_access_memory.sv
// Randomized bench for random_access_memory against a word-array reference model.
module tb_random_access_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    random_access_memory_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) bus ();

    random_access_memory #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] mem_m [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_address = '0;
        bus.i_output_enable = 1'b0;
        bus.i_write_enable = 1'b0;
        bus.i_data = '0;
        bus.i_program_mode = 1'b0;
        bus.i_load_data = '0;
        bus.i_load_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        rst = 1'b1;
        bus.i_address = 4'd3;
        bus.i_output_enable = 1'b1;
        tick(); tick();
        vectors++; if (bus.o_drive !== 1'b1) begin miscompares++; $display("FAIL rst_drive got %b want 1", bus.o_drive); end
        vectors++; if (bus.o_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h want 00", bus.o_data); end
        vectors++; if (bus.o_load_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", bus.o_load_ready); end
        vectors++; if (bus.o_load_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", bus.o_load_done); end
        vectors++; if (bus.o_load_address !== 4'd0) begin miscompares++; $display("FAIL rst_laddr got %0d want 0", bus.o_load_address); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_run_rw();
        bus.i_address = 4'd7; bus.i_data = 8'hA5; bus.i_write_enable = 1'b1; bus.i_output_enable = 1'b0;
        tick();
        mem_m[7] = 8'hA5;
        bus.i_write_enable = 1'b0; bus.i_output_enable = 1'b1;
        #1;
        vectors++; if (bus.o_data !== 8'hA5) begin miscompares++; $display("FAIL rw_read got %h want a5", bus.o_data); end
        bus.i_output_enable = 1'b0;
        #1;
        vectors++; if (bus.o_data !== 8'h00) begin miscompares++; $display("FAIL rw_oe0_data got %h want 00", bus.o_data); end
        vectors++; if (bus.o_drive !== 1'b0) begin miscompares++; $display("FAIL rw_oe0_drive got %b want 0", bus.o_drive); end
    endtask

    task automatic test_random_run();
        logic [3:0] a;
        logic [7:0] d;
        logic oe, we;
        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom_range(0, 15)); d = 8'($urandom);
            oe = 1'($urandom); we = 1'($urandom);
            bus.i_address = a; bus.i_data = d; bus.i_output_enable = oe; bus.i_write_enable = we;
            #1;
            vectors++; if (bus.o_drive !== oe) begin miscompares++; $display("FAIL rnd_drive[%0d] got %b want %b", i, bus.o_drive, oe); end
            vectors++; if (bus.o_data !== (oe ? mem_m[a] : 8'h00)) begin miscompares++; $display("FAIL rnd_data[%0d] got %h want %h", i, bus.o_data, oe ? mem_m[a] : 8'h00); end
            tick();
            if (we) mem_m[a] = d;
        end
        bus.i_write_enable = 1'b0; bus.i_output_enable = 1'b0;
    endtask

    task automatic test_full_load();
        bus.i_program_mode = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.i_load_data = 8'(8'h10 + i); bus.i_load_valid = 1'b1;
            bus.i_output_enable = 1'b1; bus.i_address = 4'(i);
            #1;
            vectors++; if (bus.o_load_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready[%0d] got %b want 1", i, bus.o_load_ready); end
            vectors++; if (bus.o_load_address !== 4'(i)) begin miscompares++; $display("FAIL full_laddr[%0d] got %0d want %0d", i, bus.o_load_address, i); end
            vectors++; if (bus.o_drive !== 1'b0) begin miscompares++; $display("FAIL full_masked[%0d] got %b want 0", i, bus.o_drive); end
            tick();
            mem_m[i] = 8'(8'h10 + i);
        end
        bus.i_load_valid = 1'b0; bus.i_output_enable = 1'b0;
        vectors++; if (bus.o_load_done !== 1'b1) begin miscompares++; $display("FAIL full_done got %b want 1", bus.o_load_done); end
        vectors++; if (bus.o_load_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_end got %b want 0", bus.o_load_ready); end
        vectors++; if (bus.o_load_address !== 4'd0) begin miscompares++; $display("FAIL full_wrap got %0d want 0", bus.o_load_address); end
        bus.i_program_mode = 1'b0;
        tick();
        vectors++; if (bus.o_load_done !== 1'b0) begin miscompares++; $display("FAIL full_done_clr got %b want 0", bus.o_load_done); end
        bus.i_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_address = 4'(i);
            #1;
            vectors++; if (bus.o_data !== mem_m[i]) begin miscompares++; $display("FAIL full_rd[%0d] got %h want %h", i, bus.o_data, mem_m[i]); end
        end
        bus.i_output_enable = 1'b0;
    endtask

    task automatic test_gapped_load();
        int cnt = 0;
        logic [7:0] d;
        bus.i_program_mode = 1'b1;
        tick();
        for (int c = 0; c < 40 && cnt < 16; c++) begin
            d = 8'($urandom);
            bus.i_load_valid = (c % 2 == 1);
            bus.i_load_data = d;
            #1;
            vectors++; if (bus.o_load_address !== 4'(cnt)) begin miscompares++; $display("FAIL gap_laddr[%0d] got %0d want %0d", c, bus.o_load_address, cnt); end
            tick();
            if (c % 2 == 1) begin mem_m[cnt] = d; cnt++; end
        end
        bus.i_load_valid = 1'b0;
        vectors++; if (bus.o_load_done !== 1'b1) begin miscompares++; $display("FAIL gap_done got %b want 1", bus.o_load_done); end
        bus.i_program_mode = 1'b0;
        tick();
        bus.i_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_address = 4'(i);
            #1;
            vectors++; if (bus.o_data !== mem_m[i]) begin miscompares++; $display("FAIL gap_rd[%0d] got %h want %h", i, bus.o_data, mem_m[i]); end
        end
        bus.i_output_enable = 1'b0;
    endtask

    task automatic test_abort_load();
        logic [7:0] d;
        bus.i_program_mode = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            bus.i_load_data = d; bus.i_load_valid = 1'b1;
            tick();
            mem_m[i] = d;
        end
        // Mode drops on the same edge as a valid byte: the byte is dropped.
        bus.i_program_mode = 1'b0; bus.i_load_data = 8'h5A;
        tick();
        bus.i_load_valid = 1'b0;
        vectors++; if (bus.o_load_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", bus.o_load_ready); end
        vectors++; if (bus.o_load_done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", bus.o_load_done); end
        bus.i_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_address = 4'(i);
            #1;
            vectors++; if (bus.o_data !== mem_m[i]) begin miscompares++; $display("FAIL abort_rd[%0d] got %h want %h", i, bus.o_data, mem_m[i]); end
        end
        bus.i_output_enable = 1'b0;
        bus.i_program_mode = 1'b1;
        tick();
        vectors++; if (bus.o_load_address !== 4'd0) begin miscompares++; $display("FAIL reenter_laddr got %0d want 0", bus.o_load_address); end
        vectors++; if (bus.o_load_ready !== 1'b1) begin miscompares++; $display("FAIL reenter_ready got %b want 1", bus.o_load_ready); end
        bus.i_program_mode = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.i_address = 4'd2; bus.i_data = 8'h3C; bus.i_write_enable = 1'b1; bus.i_program_mode = 1'b1;
        tick();
        mem_m[2] = 8'h3C;
        bus.i_write_enable = 1'b0;
        vectors++; if (bus.o_load_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", bus.o_load_ready); end
        bus.i_program_mode = 1'b0;
        tick();
        bus.i_output_enable = 1'b1;
        #1;
        vectors++; if (bus.o_data !== 8'h3C) begin miscompares++; $display("FAIL b2b_rd got %h want 3c", bus.o_data); end
        bus.i_output_enable = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        bus.i_program_mode = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom);
            bus.i_load_data = d; bus.i_load_valid = 1'b1;
            tick();
            mem_m[i] = d;
        end
        vectors++; if (bus.o_load_address !== 4'd9) begin miscompares++; $display("FAIL mid_laddr got %0d want 9", bus.o_load_address); end
        bus.i_load_data = ~mem_m[9];
        rst = 1'b1;
        #1;
        vectors++; if (bus.o_load_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %b want 0", bus.o_load_ready); end
        vectors++; if (bus.o_load_address !== 4'd0) begin miscompares++; $display("FAIL mid_rst_laddr got %0d want 0", bus.o_load_address); end
        bus.i_output_enable = 1'b1;
        #1;
        vectors++; if (bus.o_drive !== 1'b1) begin miscompares++; $display("FAIL mid_rst_run got %b want 1", bus.o_drive); end
        bus.i_output_enable = 1'b0;
        tick();
        bus.i_load_valid = 1'b0; bus.i_program_mode = 1'b0;
        rst = 1'b0;
        tick();
        bus.i_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_address = 4'(i);
            #1;
            vectors++; if (bus.o_data !== mem_m[i]) begin miscompares++; $display("FAIL mid_rd[%0d] got %h want %h", i, bus.o_data, mem_m[i]); end
        end
        bus.i_output_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_rw();
        test_random_run();
        test_full_load();
        test_gapped_load();
        test_abort_load();
        test_back_to_back();
        test_reset_mid_load();
        test_random_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/random_access_memory.md
# random_access_memory

16 x 8 program/data memory addressed by the memory address register. During run, the 4-bit MAR output selects a word: it is read onto the bus under a RAM-out control signal, or written from the bus under a RAM-in control signal. A built-in program loader fills the memory sequentially from a valid/ready byte stream while the machine is in program mode, replacing the manual address and data switches.

## Interface
Parameters:
- ADDRESS_WIDTH, 4, width of the address from the MAR; depth = 2**ADDRESS_WIDTH
- DATA_WIDTH, 8, word width

Ports:
- i_clock  input  1  system clock; all state changes on the rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_address  input  ADDRESS_WIDTH  word select, driven by the MAR output
- i_output_enable  input  1  RAM-out: drive the selected word onto the bus
- i_write_enable  input  1  RAM-in: write i_data to the selected word
- i_data  input  DATA_WIDTH  bus value to write
- o_data  output  DATA_WIDTH  selected word; all zeros when not driving
- o_drive  output  1  high when o_data is valid bus data
- i_program_mode  input  1  request a program load
- i_load_data  input  DATA_WIDTH  loader byte
- i_load_valid  input  1  loader byte present
- o_load_ready  output  1  loader accepts a byte this cycle
- o_load_address  output  ADDRESS_WIDTH  address the next accepted byte goes to
- o_load_done  output  1  all words loaded

## Operation
- Storage is an array of 2**ADDRESS_WIDTH words. It powers up all zero and is **not** cleared by i_reset.
- Loader state machine: RUN, LOAD, DONE. Reset puts it in RUN with the load pointer at 0.
- RUN:
  - o_drive = i_output_enable.
  - o_data = mem[i_address] when driving, else 0.
  - When i_write_enable is high at a rising edge, mem[i_address] <= i_data.
  - load_ready = 0, load_done = 0.
  - If i_program_mode is high at an edge: go to LOAD and set the pointer to 0.
- LOAD:
  - o_load_ready = 1. o_drive = 0 and o_data = 0. Run-side writes are ignored.
  - A handshake occurs when i_load_valid and o_load_ready are both high at an edge. It writes mem[pointer] <= i_load_data and increments the pointer.
  - The handshake at pointer = depth-1 moves the machine to DONE, and the pointer wraps to 0.
  - If i_program_mode is low at an edge: go to RUN. Words already loaded are kept, and no byte is accepted on that edge.
- DONE:
  - o_load_done = 1, o_load_ready = 0. Run-side ports stay masked.
  - If i_program_mode is low: go to RUN.
- o_load_address always shows the pointer.
- Simultaneous events:
  - RUN write on the same edge that program_mode is sampled high: the write completes and LOAD begins.
  - program_mode low on the same edge as a valid handshake in LOAD: mode wins and the byte is dropped.
- Reset in LOAD or DONE: the state returns to RUN immediately and the pointer goes to 0. A byte whose edge coincides with reset is not written.
- Reset values:
  - o_data = 0, o_drive = 0 (unless i_output_enable is high, since the read path is combinational)
  - o_load_ready = 0, o_load_done = 0, o_load_address = 0

## Timing
- Read is combinational from i_address and i_output_enable, with zero-cycle latency. It settles within the bus cycle, as the MAR-to-bus path requires.
- Write (bus or loader) takes effect at the rising edge. Data is readable in the following cycle.
- o_load_ready rises one cycle after program_mode is first sampled high.
- A full load at one byte per cycle takes depth cycles. o_load_done goes high the cycle after the last handshake.
- o_load_ready, o_load_done and o_load_address are registered-state decodes and have no combinational path from i_load_valid.

## Structure
- Shared package (ram_pkg):
  - loader state enum (RUN, LOAD, DONE)
  - DEFAULT_ADDRESS_WIDTH, DEFAULT_DATA_WIDTH
- Sub-module program_loader:
  - owns the state machine and the pointer
  - outputs the write strobe, write address, load_ready, load_done, and a run_active flag
- The top level holds the array and the write multiplexer (loader versus bus).

## Test plan
- Reset, then i_address=3 with i_output_enable=1 -> o_drive=1, o_data=0x00; o_load_ready=0, o_load_done=0.
- RUN write of 0xA5 to address 7, then read address 7 -> o_data=0xA5; i_output_enable=0 -> o_data=0, o_drive=0.
- Assert program_mode, stream bytes 0x10..0x1F with valid held high -> ready asserted for 16 handshakes, then o_load_done=1. Drop the mode, read addresses 0..15 -> 0x10..0x1F.
- Load with valid gaps (valid toggles every other cycle) -> pointer advances only on handshakes; contents are correct after 16 bytes.
- Drop program_mode after 5 bytes -> back in RUN with addresses 0..4 loaded and 5..15 unchanged. Re-entering program mode restarts at address 0.
- Assert i_reset mid-load at pointer 9 -> state RUN, pointer 0, ready 0; words 0..8 are preserved and readable.
